// File: rtl/jtag_master_pkg.sv
// jtag_master shared types and constants.
// JTAG_MASTER_TRST_EN adds the TRST pulse state.
package jtag_master_pkg;

  localparam int JTAG_MAX_BITS = 32;
  localparam int JTAG_LEN_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
`ifdef JTAG_MASTER_TRST_EN
    ST_RESP,
    ST_TRST
`else
    ST_RESP
`endif
  } jtag_state_e;

endpackage

// File: rtl/jtag_tck_tick.sv
// TCK phase timer: one-cycle pulse at the end of each CLK_DIV-cycle phase.
// Reloads on command acceptance and automatically at every phase end.
module jtag_tck_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_reload,
  output logic o_tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
    end else if (i_reload || r_cnt == 8'd0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tick = (r_cnt == 8'd0);

endmodule

// File: rtl/jtag_master.sv
// Command-driven JTAG shifter: up to 32 TMS/TDI bits per command, TDO captured.
// Define JTAG_MASTER_TRST_EN to honour cmd_trst as a timed TRST pulse.
import jtag_master_pkg::*;

module jtag_master #(
  parameter int CLK_DIV = 4
) (
  input  logic                     ext_clk,
  input  logic                     ext_rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [JTAG_LEN_W-1:0]    cmd_len,
  input  logic [JTAG_MAX_BITS-1:0] cmd_tms,
  input  logic [JTAG_MAX_BITS-1:0] cmd_tdi,
  input  logic                     cmd_trst,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [JTAG_MAX_BITS-1:0] rsp_tdo,
  output logic                     jtag_tck,
  output logic                     jtag_tms,
  output logic                     jtag_tdi,
  input  logic                     jtag_tdo,
  output logic                     jtag_trst_n,
  output logic                     busy
);

  jtag_state_e r_state;

  logic [JTAG_LEN_W-1:0]    r_len;
  logic [JTAG_LEN_W-1:0]    r_idx;
  logic [JTAG_MAX_BITS-1:0] r_tms;
  logic [JTAG_MAX_BITS-1:0] r_tdi;
  logic [JTAG_MAX_BITS-1:0] r_tdo;
  logic r_tck;
  logic r_tms_o;
  logic r_tdi_o;
  logic r_ready;
  logic r_valid;
  logic r_busy;

  logic                  w_accept;
  logic                  w_tick;
  logic [JTAG_LEN_W-1:0] w_nidx;

  assign w_accept = (r_state == ST_IDLE) & r_ready & cmd_valid;
  assign w_nidx   = r_idx + 1'b1;

  jtag_tck_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk    (ext_clk),
    .i_rst_n  (ext_rst_n),
    .i_reload (w_accept),
    .o_tick   (w_tick)
  );

`ifdef JTAG_MASTER_TRST_EN
  logic r_trst_n;
  logic r_half;
`else
  logic w_unused_trst;
  assign w_unused_trst = cmd_trst;
`endif

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_tms   <= '0;
      r_tdi   <= '0;
      r_tdo   <= '0;
      r_tck   <= 1'b0;
      r_tms_o <= 1'b1;
      r_tdi_o <= 1'b0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef JTAG_MASTER_TRST_EN
      r_trst_n <= 1'b1;
      r_half   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_len   <= cmd_len;
            r_tms   <= cmd_tms;
            r_tdi   <= cmd_tdi;
            r_idx   <= '0;
            r_tdo   <= '0;
            r_tck   <= 1'b0;
`ifdef JTAG_MASTER_TRST_EN
            if (cmd_trst) begin
              r_state  <= ST_TRST;
              r_half   <= 1'b0;
              r_trst_n <= 1'b0;
              r_tms_o  <= 1'b1;
            end else begin
              r_state <= ST_LOW;
              r_tms_o <= cmd_tms[0];
              r_tdi_o <= cmd_tdi[0];
            end
`else
            r_state <= ST_LOW;
            r_tms_o <= cmd_tms[0];
            r_tdi_o <= cmd_tdi[0];
`endif
          end
        end
        ST_LOW: begin
          if (w_tick) begin
            r_tck        <= 1'b1;
            r_tdo[r_idx] <= jtag_tdo;
            r_state      <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            r_tck <= 1'b0;
            if (r_idx == r_len) begin
              r_state <= ST_RESP;
              r_valid <= 1'b1;
            end else begin
              r_idx   <= w_nidx;
              r_tms_o <= r_tms[w_nidx];
              r_tdi_o <= r_tdi[w_nidx];
              r_state <= ST_LOW;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
`ifdef JTAG_MASTER_TRST_EN
        // Two phase ticks per requested bit keep the pulse length equal to a shift.
        ST_TRST: begin
          if (w_tick) begin
            r_half <= ~r_half;
            if (r_half) begin
              if (r_idx == r_len) begin
                r_state  <= ST_RESP;
                r_valid  <= 1'b1;
                r_trst_n <= 1'b1;
              end else begin
                r_idx <= w_nidx;
              end
            end
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign rsp_valid = r_valid;
  assign rsp_tdo   = r_tdo;
  assign jtag_tck  = r_tck;
  assign jtag_tms  = r_tms_o;
  assign jtag_tdi  = r_tdi_o;
  assign busy      = r_busy;

`ifdef JTAG_MASTER_TRST_EN
  assign jtag_trst_n = r_trst_n;
`else
  assign jtag_trst_n = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: DUT A at CLK_DIV=2, DUT B at CLK_DIV=1,
// each driving a data-register style target stub.
module tb_jtag_master;

  localparam int DA = 2;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 0, b_valid = 0;
  logic        a_rready = 0, b_rready = 0;
  logic [4:0]  len = 0;
  logic [31:0] tms = 0, tdi = 0;
  logic        trst = 0;

  logic        a_ready, a_rvalid, a_tck, a_tms, a_tdi, a_jtdo, a_trst_n, a_busy;
  logic [31:0] a_tdo;
  logic        b_ready, b_rvalid, b_tck, b_tms, b_tdi, b_jtdo, b_trst_n, b_busy;
  logic [31:0] b_tdo;

  jtag_master #(.CLK_DIV(DA)) u_dut_a (
    .ext_clk(clk), .ext_rst_n(rst_n),
    .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_len(len), .cmd_tms(tms), .cmd_tdi(tdi), .cmd_trst(trst),
    .rsp_valid(a_rvalid), .rsp_ready(a_rready), .rsp_tdo(a_tdo),
    .jtag_tck(a_tck), .jtag_tms(a_tms), .jtag_tdi(a_tdi),
    .jtag_tdo(a_jtdo), .jtag_trst_n(a_trst_n), .busy(a_busy)
  );

  jtag_master #(.CLK_DIV(DB)) u_dut_b (
    .ext_clk(clk), .ext_rst_n(rst_n),
    .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_len(len), .cmd_tms(tms), .cmd_tdi(tdi), .cmd_trst(trst),
    .rsp_valid(b_rvalid), .rsp_ready(b_rready), .rsp_tdo(b_tdo),
    .jtag_tck(b_tck), .jtag_tms(b_tms), .jtag_tdi(b_tdi),
    .jtag_tdo(b_jtdo), .jtag_trst_n(b_trst_n), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Target stub: presents preload bit k, advancing on each TCK falling edge.
  int a_neg = 0, a_base = 0, a_k;
  int b_neg = 0, b_base = 0, b_k;
  logic [31:0] a_pre = 0, b_pre = 0;
  always @(negedge a_tck) a_neg <= a_neg + 1;
  always @(negedge b_tck) b_neg <= b_neg + 1;
  always_comb begin
    a_k = a_neg - a_base;
    a_jtdo = (a_k >= 0 && a_k < 32) ? a_pre[a_k[4:0]] : 1'b0;
  end
  always_comb begin
    b_k = b_neg - b_base;
    b_jtdo = (b_k >= 0 && b_k < 32) ? b_pre[b_k[4:0]] : 1'b0;
  end

  // Pin observer for DUT A, sampled mid-cycle.
  int   r_cyc[$];
  logic r_tms[$];
  logic r_tdi[$];
  int   m_high = 0, m_trst_low = 0, m_tms_low = 0;
  logic prev_tck = 0;
  always @(negedge clk) begin
    if (a_tck && !prev_tck) begin
      r_cyc.push_back(cyc);
      r_tms.push_back(a_tms);
      r_tdi.push_back(a_tdi);
    end
    if (a_tck) m_high++;
    if (!a_trst_n) m_trst_low++;
    if (!a_tms) m_tms_low++;
    prev_tck = a_tck;
  end

  int s_rise, s_high, s_trst, s_tmslow;

  task automatic send(input bit sel, input logic [4:0] l, input logic [31:0] ms,
                      input logic [31:0] di, input logic tr, input logic [31:0] pre,
                      output int t_acc);
    bit ok;
    @(posedge clk); #1;
    len = l; tms = ms; tdi = di; trst = tr;
    if (sel) begin b_pre = pre; b_base = b_neg; b_valid = 1; end
    else     begin a_pre = pre; a_base = a_neg; a_valid = 1; end
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sel ? b_ready : a_ready) begin ok = 1; break; end
    end
    t_acc = cyc + 1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=0 after 50 cycles, required 1");
    end
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    s_rise = r_cyc.size(); s_high = m_high; s_trst = m_trst_low; s_tmslow = m_tms_low;
    len = 5'($urandom); tms = $urandom; tdi = $urandom; trst = 1'($urandom);
  endtask

  task automatic wait_rsp(input bit sel, input int t_acc, output int lat,
                          output logic [31:0] rtdo);
    bit ok = 0;
    lat = -1; rtdo = 'x;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sel ? b_rvalid : a_rvalid) begin ok = 1; break; end
    end
    if (ok) begin
      lat = cyc - t_acc;
      rtdo = sel ? b_tdo : a_tdo;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=0 after 3000 cycles, required 1");
    end
    #1;
  endtask

  task automatic ack(input bit sel, input int hold);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    if (sel) b_rready = 1; else a_rready = 1;
    @(posedge clk); #1;
    a_rready = 0; b_rready = 0;
  endtask

  function automatic logic [31:0] mask_of(input int l);
    return 32'((64'd1 << (l + 1)) - 64'd1);
  endfunction

  task automatic test_reset;
    rst_n = 0;
    a_valid = 0; b_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_tck, a_tms, a_tdi, a_trst_n, a_ready, a_rvalid, a_busy} !== 7'b0101000 ||
        a_tdo !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: tck/tms/tdi/trst_n/ready/valid/busy=%b tdo=%h, required 0101000 tdo=0",
               {a_tck, a_tms, a_tdi, a_trst_n, a_ready, a_rvalid, a_busy}, a_tdo);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: cmd_ready=%b, required 0", a_ready);
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: a=%b b=%b, required 1 1", a_ready, b_ready);
    end
  endtask

  task automatic test_fixed;
    int t, lat, bad;
    logic [31:0] pre, di, got;
    pre = $urandom; di = $urandom;
    send(0, 5'd4, 32'h1F, di, 1'b0, pre, t);
    wait_rsp(0, t, lat, got);
    checks++;
    if (lat !== 20) begin
      errors++; $display("FAIL fixed_latency: %0d cycles, required 20", lat);
    end
    checks++;
    if (r_cyc.size() - s_rise !== 5) begin
      errors++; $display("FAIL fixed_pulses: %0d, required 5", r_cyc.size() - s_rise);
    end
    bad = 0;
    for (int i = s_rise + 1; i < r_cyc.size(); i++)
      if (r_cyc[i] - r_cyc[i-1] != 4) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL fixed_period: %0d periods not 4, required 0", bad);
    end
    checks++;
    if (m_tms_low - s_tmslow !== 0) begin
      errors++; $display("FAIL fixed_tms: TMS low for %0d cycles, required 0", m_tms_low - s_tmslow);
    end
    checks++;
    if (got !== (pre & 32'h1F)) begin
      errors++; $display("FAIL fixed_tdo: %h, required %h", got, pre & 32'h1F);
    end
    ack(0, 0);
  endtask

  task automatic test_idcode;
    int t, lat;
    logic [31:0] got;
    send(1, 5'd31, 32'h0, 32'h0, 1'b0, 32'h4BA00477, t);
    wait_rsp(1, t, lat, got);
    checks++;
    if (got !== 32'h4BA00477) begin
      errors++; $display("FAIL idcode: %h, required 4ba00477", got);
    end
    checks++;
    if (lat !== 2 * DB * 32) begin
      errors++; $display("FAIL idcode_latency: %0d, required %0d", lat, 2 * DB * 32);
    end
    ack(1, 1);
  endtask

  task automatic test_random;
    int t, lat, n, l, first_ok;
    logic [31:0] pre, ms, di, got, m, om, od;
    for (int it = 0; it < 14; it++) begin
      l = (it == 0) ? 0 : (it == 1) ? 31 : int'($urandom_range(0, 31));
      pre = $urandom; ms = $urandom; di = $urandom; m = mask_of(l);
      send(0, 5'(l), ms, di, 1'b0, pre, t);
      wait_rsp(0, t, lat, got);
      n = r_cyc.size() - s_rise;
      om = 0; od = 0;
      for (int i = 0; i < n && i < 32; i++) begin
        om[i] = r_tms[s_rise + i];
        od[i] = r_tdi[s_rise + i];
      end
      first_ok = (n > 0) ? int'(r_cyc[s_rise] == t + DA) : 0;
      checks++;
      if (lat !== 2 * DA * (l + 1)) begin
        errors++; $display("FAIL rand_latency: len=%0d got %0d, required %0d", l, lat, 2 * DA * (l + 1));
      end
      checks++;
      if (n !== l + 1 || first_ok !== 1) begin
        errors++; $display("FAIL rand_pulses: len=%0d pulses %0d first_ok %0d, required %0d 1", l, n, first_ok, l + 1);
      end
      checks++;
      if (2 * (m_high - s_high) !== lat) begin
        errors++; $display("FAIL rand_duty: high %0d of %0d cycles, required half", m_high - s_high, lat);
      end
      checks++;
      if (om !== (ms & m) || od !== (di & m)) begin
        errors++; $display("FAIL rand_pins: tms %h tdi %h, required %h %h", om, od, ms & m, di & m);
      end
      checks++;
      if (got !== (pre & m)) begin
        errors++; $display("FAIL rand_tdo: len=%0d %h, required %h", l, got, pre & m);
      end
      ack(0, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_backpressure;
    int t, lat, bad;
    logic [31:0] got;
    send(0, 5'd7, $urandom, $urandom, 1'b0, $urandom, t);
    wait_rsp(0, t, lat, got);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_rvalid !== 1 || a_tdo !== got || a_ready !== 0 || a_tck !== 0 || a_busy !== 1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    ack(0, 0);
    @(negedge clk);
    checks++;
    if (a_rvalid !== 0 || a_busy !== 0 || a_ready !== 1) begin
      errors++; $display("FAIL bp_release: valid=%b busy=%b ready=%b, required 0 0 1", a_rvalid, a_busy, a_ready);
    end
  endtask

  task automatic test_reset_mid;
    int t, seen;
    bit ok = 0;
    send(0, 5'd15, $urandom, $urandom, 1'b0, $urandom, t);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (r_cyc.size() - s_rise >= 4) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_bit3_timeout: bit 3 not reached, required reached");
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({a_tck, a_tms, a_tdi, a_trst_n, a_ready, a_rvalid, a_busy} !== 7'b0101000 ||
        a_tdo !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_out: pins=%b tdo=%h, required 0101000 tdo=0",
               {a_tck, a_tms, a_tdi, a_trst_n, a_ready, a_rvalid, a_busy}, a_tdo);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_rvalid || a_busy || a_tck) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL mid_no_rsp: %0d active cycles after abort, required 0", seen);
    end
  endtask

  task automatic test_trst;
    int t, lat;
    logic [31:0] pre, got;
    pre = $urandom | 32'hF;
    send(0, 5'd3, $urandom, $urandom, 1'b1, pre, t);
    wait_rsp(0, t, lat, got);
    checks++;
    if (lat !== 16) begin
      errors++; $display("FAIL trst_latency: %0d, required 16", lat);
    end
`ifdef JTAG_MASTER_TRST_EN
    checks++;
    if (m_trst_low - s_trst !== 16) begin
      errors++; $display("FAIL trst_low: %0d cycles, required 16", m_trst_low - s_trst);
    end
    checks++;
    if (r_cyc.size() - s_rise !== 0 || m_tms_low - s_tmslow !== 0) begin
      errors++; $display("FAIL trst_pins: tck rises %0d tms-low %0d, required 0 0",
                         r_cyc.size() - s_rise, m_tms_low - s_tmslow);
    end
    checks++;
    if (got !== 32'd0) begin
      errors++; $display("FAIL trst_tdo: %h, required 0", got);
    end
`else
    checks++;
    if (m_trst_low - s_trst !== 0) begin
      errors++; $display("FAIL trst_ignored: trst_n low %0d cycles, required 0", m_trst_low - s_trst);
    end
    checks++;
    if (r_cyc.size() - s_rise !== 4) begin
      errors++; $display("FAIL trst_shift: %0d pulses, required 4", r_cyc.size() - s_rise);
    end
    checks++;
    if (got !== (pre & 32'hF)) begin
      errors++; $display("FAIL trst_tdo: %h, required %h", got, pre & 32'hF);
    end
`endif
    ack(0, 0);
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_idcode;
    test_random;
    test_backpressure;
    test_trst;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter CLK_DIV, default 4: TCK half-period in ext_clk cycles; legal range 1..255.
REQ-002 ext_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 ext_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted on any cycle where cmd_valid and cmd_ready are both high.
REQ-006 cmd_len  input  5  bit count minus 1 (0 = 1 bit, 31 = 32 bits).
REQ-007 cmd_tms  input  32  per-bit TMS values, LSB shifted first.
REQ-008 cmd_tdi  input  32  per-bit TDI values, LSB shifted first.
REQ-009 cmd_trst  input  1  TRST pulse command (feature-dependent, see REQ-031).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed on any cycle where rsp_valid and rsp_ready are both high.
REQ-012 rsp_tdo  output  32  captured TDO; bit i is bit i of the shift; bits above cmd_len are 0.
REQ-013 jtag_tck, jtag_tms, jtag_tdi  output  1 each  drive target TAP.
REQ-014 jtag_tdo  input  1  target TDO; treated as synchronous to ext_clk, no synchronizer inside.
REQ-015 jtag_trst_n  output  1  target TAP reset, active-low.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, LOW, HIGH, RESP; the feature of REQ-031 adds TRST.
REQ-018 IDLE: cmd_ready=1; on acceptance, latch len/tms/tdi, clear bit index and the TDO shift register, then enter LOW.
REQ-019 Entry to LOW (acceptance edge, or falling TCK edge): drive jtag_tms/jtag_tdi with the current bit; jtag_tck=0; stay CLK_DIV cycles.
REQ-020 LOW->HIGH: jtag_tck=1; on that same edge, sample jtag_tdo into rsp_tdo[bit index]; stay CLK_DIV cycles.
REQ-021 HIGH exit: jtag_tck=0; if bit index==len, go to RESP; else increment the index and go to LOW with the next bit driven on that same edge.
REQ-022 rsp_valid rises exactly 2*CLK_DIV*(cmd_len+1) cycles after the acceptance edge; TCK duty cycle is 50%.
REQ-023 RESP: rsp_valid held with rsp_tdo stable until the handshake; jtag_tck stays 0; jtag_tms/jtag_tdi hold the last bit; go to IDLE on the handshake edge.
REQ-024 cmd_ready=0 outside IDLE; a new command cannot be accepted on the cycle a response is consumed, so there is at least 1 idle cycle between commands.
REQ-025 Command inputs are ignored after acceptance; changes during a shift have no effect.
REQ-026 Bit index width is 5 bits; index==31 ends the shift without wrap-around.

Reset
REQ-027 While ext_rst_n is low, outputs SHALL be: jtag_tck=0, jtag_tms=1, jtag_tdi=0, jtag_trst_n=1, cmd_ready=0, rsp_valid=0, rsp_tdo=0, busy=0; FSM forced to IDLE.
REQ-028 On the first ext_clk edge after deassertion, cmd_ready=1.
REQ-029 Reset mid-shift aborts immediately: no response is produced and the partial shift is discarded.

Configuration
REQ-030 Macro JTAG_MASTER_TRST_EN selects TRST support.
REQ-031 With the macro defined, an accepted command with cmd_trst=1:
- drives jtag_trst_n=0 for 2*CLK_DIV*(cmd_len+1) cycles;
- holds jtag_tck=0 and jtag_tms=1;
- then enters RESP with rsp_tdo=0.
REQ-032 Without the macro: cmd_trst is ignored, the command is treated as a normal shift, jtag_trst_n is tied 1, and the TRST state does not exist.

Structure
REQ-033 Package jtag_master_pkg SHALL hold:
- the FSM state enum;
- constants JTAG_MAX_BITS=32 and JTAG_LEN_W=5.
REQ-034 Sub-module jtag_tck_tick (CLK_DIV down-counter) SHALL emit a one-cycle phase-end pulse; it reloads on acceptance and on every phase change.

Verification
REQ-035 Reset check: hold ext_rst_n low, then release -> outputs match REQ-027, and cmd_ready=1 one cycle after release.
REQ-036 CLK_DIV=2, cmd_len=4, cmd_tms=0x1F -> 5 TCK pulses with period 4, TMS=1 throughout, rsp_valid 20 cycles after acceptance.
REQ-037 IDCODE read: CLK_DIV=1, cmd_len=31, cmd_tdi=0, TAP model in Shift-DR returning 0x4BA00477 -> rsp_tdo=0x4BA00477.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_tdo stable, cmd_ready=0, jtag_tck=0; the handshake returns the FSM to IDLE.
REQ-039 Reset during bit 3 of a 16-bit shift -> outputs revert to reset values asynchronously, and no rsp_valid ever appears.
REQ-040 Macro defined, cmd_trst=1, cmd_len=3, CLK_DIV=2 -> jtag_trst_n low for 16 cycles, no TCK edges, rsp_tdo=0.
